// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end for one shared iterative shift unit.
// A winner's operands are latched in IDLE and held until its done pulse.
module shift_arbiter #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic [R-1:0]   i_req,
    input  logic [R-1:0]   i_req_direction,
    input  logic [R-1:0]   i_req_rotate,
    input  logic [R*N-1:0] i_req_iterations,
    input  logic [R*N-1:0] i_req_value,
    output logic [R-1:0]   o_grant,
    output logic [R-1:0]   o_done,
    output logic [N-1:0]   o_result,
    output logic           o_busy,
    output logic           o_sh_start,
    output logic           o_sh_direction,
    output logic           o_sh_rotate,
    output logic [N-1:0]   o_sh_iterations,
    output logic [N-1:0]   o_sh_value,
    input  logic           i_sh_finished,
    input  logic [N-1:0]   i_sh_value
);

    localparam int W = (R > 1) ? $clog2(R) : 1;
    localparam logic [R-1:0] ONE = R'(1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE
    } state_t;

    state_t       state;
    logic [W-1:0] ptr;
    logic [W-1:0] owner;
    logic [W-1:0] cand;
    logic [W-1:0] winner;
    logic         found;

    // First requester after the pointer, wrapping modulo R.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= R; i++) begin
            cand = W'((int'(ptr) + i) % R);
            if (!found && i_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state           <= IDLE;
            ptr             <= W'(R - 1);
            owner           <= '0;
            o_grant         <= '0;
            o_done          <= '0;
            o_result        <= '0;
            o_busy          <= 1'b0;
            o_sh_start      <= 1'b0;
            o_sh_direction  <= 1'b0;
            o_sh_rotate     <= 1'b0;
            o_sh_iterations <= '0;
            o_sh_value      <= '0;
        end else begin
            o_grant    <= '0;
            o_done     <= '0;
            o_sh_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        owner           <= winner;
                        o_sh_direction  <= i_req_direction[winner];
                        o_sh_rotate     <= i_req_rotate[winner];
                        o_sh_iterations <= i_req_iterations[int'(winner)*N +: N];
                        o_sh_value      <= i_req_value[int'(winner)*N +: N];
                        o_grant         <= ONE << winner;
                        o_sh_start      <= 1'b1;
                        o_busy          <= 1'b1;
                        state           <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // A zero-count op finishes in the start cycle itself.
                    if (i_sh_finished) begin
                        o_result <= i_sh_value;
                        o_done   <= ONE << owner;
                        state    <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_sh_finished) begin
                        o_result <= i_sh_value;
                        o_done   <= ONE << owner;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    ptr    <= owner;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
